// File: rtl/bus_pkg.sv
// Shared types and constants for the two-master serial bus arbiter.
package bus_pkg;

    localparam int NUM_MASTERS = 2;
    localparam int NUM_SLAVES  = 3;
    localparam int CNT_W       = 7;

    localparam logic [CNT_W-1:0] ACK_TIMEOUT    = 7'd8;
    localparam logic [CNT_W-1:0] TXN_TIMEOUT    = 7'd64;
    localparam logic [1:0]       INVALID_SLV_ID = 2'd3;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        GRANT    = 3'd1,
        WAIT_ACK = 3'd2,
        ACTIVE   = 3'd3,
        RELEASE  = 3'd4
    } bus_state_e;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == 7'h7F) ? v : v + 7'd1;
    endfunction

    function automatic logic [NUM_MASTERS-1:0] master_onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational two-way round-robin pick; last_gnt names the master served last.
module rr_arbiter
    import bus_pkg::*;
(
    input  logic [NUM_MASTERS-1:0] req,
    input  logic                   last_gnt,
    output logic                   win_valid,
    output logic                   win_idx
);

    // Tie goes to the master that was not served last.
    always_comb begin
        win_valid = |req;
        case (req)
            2'b01:   win_idx = 1'b0;
            2'b10:   win_idx = 1'b1;
            2'b11:   win_idx = ~last_gnt;
            default: win_idx = 1'b0;
        endcase
    end

endmodule

// File: rtl/bus_arbiter.sv
// Two-master to three-slave serial bus arbiter with ack and transaction watchdogs.
module bus_arbiter
    import bus_pkg::*;
(
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [NUM_MASTERS-1:0] m_req,
    input  logic [1:0]             m0_slv_id,
    input  logic [1:0]             m1_slv_id,
    input  logic [NUM_MASTERS-1:0] m_tx,
    output logic [NUM_MASTERS-1:0] m_rx,
    output logic [NUM_MASTERS-1:0] m_gnt,
    output logic [NUM_MASTERS-1:0] m_err,
    output logic [NUM_SLAVES-1:0]  s_rx,
    input  logic [NUM_SLAVES-1:0]  s_tx,
    output logic                   busy
);

    bus_state_e             state_q, state_d;
    logic                   gidx_q, gidx_d;
    logic [1:0]             sel_q, sel_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   ptr_q, ptr_d;
    logic [NUM_MASTERS-1:0] gnt_q, gnt_d;
    logic [NUM_MASTERS-1:0] err_q, err_d;

    logic       win_valid;
    logic       win_idx;
    logic [1:0] win_id;
    logic       req_g;
    logic       tx_g;
    logic       stx_sel;
    logic       route_en;

    rr_arbiter u_rr (
        .req       (m_req),
        .last_gnt  (ptr_q),
        .win_valid (win_valid),
        .win_idx   (win_idx)
    );

    // Select the granted master's lines and the selected slave's tx.
    always_comb begin
        win_id = win_idx ? m1_slv_id : m0_slv_id;
        req_g  = m_req[gidx_q];
        tx_g   = m_tx[gidx_q];
        case (sel_q)
            2'd0:    stx_sel = s_tx[0];
            2'd1:    stx_sel = s_tx[1];
            2'd2:    stx_sel = s_tx[2];
            default: stx_sel = 1'b1;
        endcase
    end

    // Next-state, grant and error-pulse logic.
    always_comb begin
        state_d = state_q;
        gidx_d  = gidx_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        err_d   = 2'b00;
        case (state_q)
            IDLE: begin
                if (win_valid) begin
                    if (win_id == INVALID_SLV_ID) begin
                        err_d = master_onehot(win_idx);
                        ptr_d = win_idx;
                    end else begin
                        state_d = GRANT;
                        gidx_d  = win_idx;
                        sel_d   = win_id;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            GRANT: begin
                if (!req_g) begin
                    state_d = RELEASE;
                end else if (!tx_g) begin
                    state_d = WAIT_ACK;
                end else begin
                    state_d = GRANT;
                end
            end
            WAIT_ACK: begin
                if (!stx_sel) begin
                    state_d = ACTIVE;
                end else if (cnt_q >= ACK_TIMEOUT - 7'd1) begin
                    err_d   = master_onehot(gidx_q);
                    state_d = RELEASE;
                end else begin
                    state_d = WAIT_ACK;
                end
            end
            ACTIVE: begin
                // A clean end of frame wins over a simultaneous watchdog expiry.
                if (!req_g && stx_sel) begin
                    state_d = RELEASE;
                end else if (cnt_q >= TXN_TIMEOUT - 7'd1) begin
                    err_d   = master_onehot(gidx_q);
                    state_d = RELEASE;
                end else begin
                    state_d = ACTIVE;
                end
            end
            RELEASE: begin
                state_d = IDLE;
                ptr_d   = gidx_q;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (state_d != state_q) begin
            cnt_d = 7'd0;
        end else begin
            cnt_d = sat_inc(cnt_q);
        end

        if ((state_d == GRANT) || (state_d == WAIT_ACK) || (state_d == ACTIVE)) begin
            gnt_d = master_onehot(gidx_d);
        end else begin
            gnt_d = 2'b00;
        end
    end

    // Transparent line routing while a master owns the bus; idle-high otherwise.
    always_comb begin
        route_en = rstn && ((state_q == GRANT) || (state_q == WAIT_ACK) || (state_q == ACTIVE));
        s_rx     = 3'b111;
        m_rx     = 2'b11;
        if (route_en) begin
            case (sel_q)
                2'd0:    s_rx[0] = tx_g;
                2'd1:    s_rx[1] = tx_g;
                2'd2:    s_rx[2] = tx_g;
                default: s_rx    = 3'b111;
            endcase
            m_rx[gidx_q] = stx_sel;
        end else begin
            s_rx = 3'b111;
            m_rx = 2'b11;
        end
    end

    // State registers; pointer resets to master 1 so master 0 takes the first tie.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            gidx_q  <= 1'b0;
            sel_q   <= 2'd0;
            cnt_q   <= 7'd0;
            ptr_q   <= 1'b1;
            gnt_q   <= 2'b00;
            err_q   <= 2'b00;
        end else begin
            state_q <= state_d;
            gidx_q  <= gidx_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            err_q   <= err_d;
        end
    end

    assign m_gnt = gnt_q;
    assign m_err = err_q;
    assign busy  = (state_q != IDLE);

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 The block SHALL have a clock input: clk, input, 1, rising-edge clock for all state.
REQ-002 The block SHALL have a reset input: rstn, input, 1, asynchronous, active-low reset.
REQ-003 The block SHALL have input m_req, 2 bits: per-master bus request, held high until the master's frame completes.
REQ-004 The block SHALL have inputs m0_slv_id and m1_slv_id, 2 bits each: target slave ID, valid while m_req is high (0..2 valid, 3 invalid).
REQ-005 The block SHALL have input m_tx, 2 bits: per-master serial line toward the bus (idle 1).
REQ-006 The block SHALL have output m_rx, 2 bits: per-master serial line from the bus (idle 1).
REQ-007 The block SHALL have output m_gnt, 2 bits: one-hot grant.
REQ-008 The block SHALL have output m_err, 2 bits: one-cycle error pulse per master.
REQ-009 The block SHALL have output s_rx, 3 bits: per-slave serial line toward each slave's rx (idle 1).
REQ-010 The block SHALL have input s_tx, 3 bits: per-slave serial line from each slave's tx (idle 1).
REQ-011 The block SHALL have output busy, 1 bit: high in every state except IDLE.

Function
REQ-012 States SHALL be: IDLE, GRANT, WAIT_ACK, ACTIVE and RELEASE.
REQ-013 Arbitration in IDLE SHALL be two-way round robin: with both m_req bits high, the master not granted last wins; a single requester wins outright.
REQ-014 If the winner's slv_id is 3, then: m_err[winner] SHALL pulse for 1 cycle, no grant SHALL be issued, the round-robin pointer SHALL advance past the winner, and the state SHALL remain IDLE.
REQ-015 On a valid win, the next edge SHALL assert m_gnt[winner], latch sel = slv_id and enter GRANT; sel SHALL be held until IDLE is re-entered.
REQ-016 Routing while not IDLE: s_rx[sel] = m_tx[g] and m_rx[g] = s_tx[sel], combinationally; all other s_rx and m_rx bits SHALL be 1.
REQ-017 GRANT -> WAIT_ACK on m_tx[g]==0 (start bit); GRANT -> RELEASE if m_req[g] drops first.
REQ-018 WAIT_ACK -> ACTIVE on s_tx[sel]==0; the slave acknowledges 2 cycles after the start bit.
REQ-019 Ack timeout: if no ack arrives within ACK_TIMEOUT=8 cycles of entering WAIT_ACK, m_err[g] SHALL pulse and the state SHALL go to RELEASE.
REQ-020 ACTIVE -> RELEASE when m_req[g]==0 and s_tx[sel]==1 in the same cycle.
REQ-021 Transaction watchdog: if ACTIVE persists for TXN_TIMEOUT=64 cycles, m_err[g] SHALL pulse and the state SHALL go to RELEASE.
REQ-022 RELEASE SHALL last exactly 1 cycle: m_gnt=0, all lines forced to 1, pointer = g; then IDLE.
REQ-023 A requester SHALL be re-arbitrated no earlier than the cycle after RELEASE; minimum grant-to-grant gap is 2 cycles.
REQ-024 Requests arriving or changing while not IDLE SHALL be ignored until IDLE; slv_id changes after the grant SHALL have no effect.
REQ-025 Timeout counters SHALL be 7 bits, cleared on every state change, and saturating.

Reset
REQ-026 On rstn low, immediately and asynchronously: state=IDLE, m_gnt=0, m_err=0, busy=0, counters=0, sel=0, and the pointer set so that master 0 wins the first tie.
REQ-027 While in reset, all m_rx and s_rx bits SHALL be 1, including during an in-flight frame.

Structure
REQ-028 A shared package bus_pkg SHALL hold: the state enum, NUM_MASTERS=2, NUM_SLAVES=3, ACK_TIMEOUT=8, TXN_TIMEOUT=64 and INVALID_SLV_ID=2'd3.
REQ-029 A sub-module rr_arbiter SHALL implement the combinational 2-way round-robin pick from m_req and the pointer.

Verification
REQ-030 Master 0 alone, slv_id=1, write frame to a slave model: grant 1 cycle after req; ack seen 2 cycles after start; 8 data bits reach s_rx[1]; req dropped -> RELEASE -> IDLE; m_err stays 0.
REQ-031 Both masters request simultaneously, repeated twice, with masters re-requesting: grant order is 0, 1, 0, 1.
REQ-032 Master 1 with slv_id=3: m_err[1] pulses 1 cycle, no grant; pending master 0 (id 2) is granted on the next arbitration.
REQ-033 Start bit to slave 0 with s_tx[0] held 1: m_err pulses 8 cycles after WAIT_ACK entry; RELEASE follows; busy falls.
REQ-034 Read frame from slave 2 returning 0x1A: bits 0,1,0,1,1,0,0,0 appear on m_rx[g] in that order; other lines stay 1.
REQ-035 rstn pulsed low mid-ACTIVE: m_gnt=0 and all lines 1 in the same cycle; after release, master 0 wins the first tie.
